// File: rtl/xsw_pkg.sv
// Shared constants and types for the xswitch output scheduler.
//   NPORT       number of input/output ports
//   AW / DW     per-port address / data width
//   port_idx_t  index of one port (0..NPORT-1)
//   cfg_entry_t one output's address-table entry {en, addr}
package xsw_pkg;
  localparam int NPORT = 8;
  localparam int AW    = 8;
  localparam int DW    = 8;

  typedef logic [2:0] port_idx_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
  } cfg_entry_t;
endpackage

// File: rtl/xsw_rr_arb.sv
// 8-way round-robin arbiter with its own pointer register.
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : one request bit per input
//   advance    : this output may accept a word this cycle; when low, no grant
//                is issued and the pointer stays put
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the granted input (valid when |gnt)
// Search order is ptr, ptr+1, ..., wrapping; after a grant to input i the
// pointer moves to i+1 so that input has lowest priority next time.
module xsw_rr_arb
  import xsw_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NPORT-1:0] req,
  input  logic             advance,
  output logic [NPORT-1:0] gnt,
  output port_idx_t        gnt_idx
);

  port_idx_t ptr;
  logic      found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      if (advance && !found && req[ptr + port_idx_t'(k)]) begin
        found                     = 1'b1;
        gnt[ptr + port_idx_t'(k)] = 1'b1;
        gnt_idx                   = ptr + port_idx_t'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= gnt_idx + port_idx_t'(1);
    end
  end

endmodule

// File: rtl/xsw_out_sched.sv
// Ingress scheduler for the 8-port xswitch.
// Each cycle every requesting input's destination address is looked up in a
// programmable per-output table; each output round-robins among the inputs
// that target it and issues at most one registered push to its FIFO.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   addr_in, data_in      per-input address/data, lane i = [8i +: 8]
//   wr_en / data_rcv      input request / accept (see handshake note below)
//   port_en, port_wr      config strobe; 1 = write, 0 = read
//   port_sel              output select (write: any-hot, read: lowest set bit)
//   port_addr             write payload: [7:0] address, [8] enable
//   cfg_rdata             registered read data {en, addr}
//   fifo_full, fifo_af    per-output FIFO full / almost-full
//   push, push_data       registered per-output FIFO write strobe and data
//   push_src              source input of each push, lane j = [3j +: 3]
//   drop, drop_cnt        registered pulse per dropped word, saturating total
//
// Handshake: wr_en[i] is a valid that the source holds together with stable
// addr/data until data_rcv[i] is seen high in the same cycle; a word moves
// exactly on cycles where wr_en[i] && data_rcv[i]. data_rcv is combinational
// and never asserts without wr_en.
module xsw_out_sched
  import xsw_pkg::*;
#(
  parameter bit DROP_UNMATCHED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT*AW-1:0] addr_in,
  input  logic [NPORT*DW-1:0] data_in,
  input  logic [NPORT-1:0]    wr_en,
  output logic [NPORT-1:0]    data_rcv,
  input  logic                port_en,
  input  logic                port_wr,
  input  logic [NPORT-1:0]    port_sel,
  input  logic [15:0]         port_addr,
  output logic [AW:0]         cfg_rdata,
  input  logic [NPORT-1:0]    fifo_full,
  input  logic [NPORT-1:0]    fifo_af,
  output logic [NPORT-1:0]    push,
  output logic [NPORT*DW-1:0] push_data,
  output logic [NPORT*3-1:0]  push_src,
  output logic [NPORT-1:0]    drop,
  output logic [15:0]         drop_cnt
);

  cfg_entry_t       tab [NPORT];
  logic [NPORT-1:0] hit;
  port_idx_t        tgt [NPORT];
  logic [NPORT-1:0] req [NPORT];
  logic [NPORT-1:0] gnt [NPORT];
  port_idx_t        gnt_idx [NPORT];
  logic [NPORT-1:0] eligible;
  logic [NPORT-1:0] accept;
  logic [NPORT-1:0] drop_acc;
  logic [16:0]      drop_sum;
  cfg_entry_t       rd_entry;
  logic             rd_found;
  logic             cfg_unused;

  assign cfg_unused = ^port_addr[15:9];

  // Address decode: lowest enabled output with a matching address wins, so a
  // duplicated address never reaches the higher-index output.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      hit[i] = 1'b0;
      tgt[i] = '0;
      for (int j = 0; j < NPORT; j++) begin
        if (!hit[i] && tab[j].en && tab[j].addr == addr_in[AW*i +: AW]) begin
          hit[i] = 1'b1;
          tgt[i] = port_idx_t'(j);
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      req[j] = '0;
      for (int i = 0; i < NPORT; i++) begin
        req[j][i] = wr_en[i] && hit[i] && (tgt[i] == port_idx_t'(j));
      end
    end
  end

  // A push already registered for an almost-full FIFO will fill it, so that
  // output must sit out this cycle as well.
  assign eligible = ~fifo_full & ~(push & fifo_af);

  for (genvar j = 0; j < NPORT; j++) begin : g_arb
    xsw_rr_arb u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req[j]),
      .advance (eligible[j]),
      .gnt     (gnt[j]),
      .gnt_idx (gnt_idx[j])
    );
  end

  always_comb begin
    accept = '0;
    for (int j = 0; j < NPORT; j++) begin
      accept = accept | gnt[j];
    end
  end

  assign drop_acc = wr_en & ~hit & {NPORT{DROP_UNMATCHED}};
  assign data_rcv = accept | drop_acc;
  assign drop_sum = {1'b0, drop_cnt} + 17'($countones(drop_acc));

  // Config read returns the lowest selected entry; empty select reads zero.
  always_comb begin
    rd_entry = '0;
    rd_found = 1'b0;
    for (int j = 0; j < NPORT; j++) begin
      if (!rd_found && port_sel[j]) begin
        rd_found = 1'b1;
        rd_entry = tab[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NPORT; j++) begin
        tab[j].en   <= 1'b0;
        tab[j].addr <= AW'(j);
      end
      push      <= '0;
      push_data <= '0;
      push_src  <= '0;
      drop      <= '0;
      drop_cnt  <= '0;
      cfg_rdata <= '0;
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        push[j] <= |gnt[j];
        if (|gnt[j]) begin
          push_data[DW*j +: DW] <= data_in[DW*gnt_idx[j] +: DW];
          push_src[3*j +: 3]    <= gnt_idx[j];
        end
        if (port_en && port_wr && port_sel[j]) begin
          tab[j].en   <= port_addr[8];
          tab[j].addr <= port_addr[7:0];
        end
      end
      drop     <= drop_acc;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (port_en && !port_wr) begin
        cfg_rdata <= rd_entry;
      end
    end
  end

endmodule

// File: tb/tb_xsw_out_sched.sv
module tb_xsw_out_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] addr_in, data_in;
  logic [7:0]  wr_en, port_sel, fifo_full, fifo_af;
  logic        port_en, port_wr;
  logic [15:0] port_addr;
  logic [7:0]  data_rcv, push, drop;
  logic [8:0]  cfg_rdata;
  logic [63:0] push_data;
  logic [23:0] push_src;
  logic [15:0] drop_cnt;
  // second instance holds unmatched words instead of dropping them
  logic [7:0]  data_rcv_h, push_h, drop_h;
  logic [8:0]  cfg_rdata_h;
  logic [63:0] push_data_h;
  logic [23:0] push_src_h;
  logic [15:0] drop_cnt_h;

  always #5 clk = ~clk;

  xsw_out_sched #(.DROP_UNMATCHED(1'b1)) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
    .data_rcv(data_rcv), .port_en(port_en), .port_wr(port_wr), .port_sel(port_sel),
    .port_addr(port_addr), .cfg_rdata(cfg_rdata), .fifo_full(fifo_full), .fifo_af(fifo_af),
    .push(push), .push_data(push_data), .push_src(push_src), .drop(drop), .drop_cnt(drop_cnt));

  xsw_out_sched #(.DROP_UNMATCHED(1'b0)) dut_h (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
    .data_rcv(data_rcv_h), .port_en(port_en), .port_wr(port_wr), .port_sel(port_sel),
    .port_addr(port_addr), .cfg_rdata(cfg_rdata_h), .fifo_full(fifo_full), .fifo_af(fifo_af),
    .push(push_h), .push_data(push_data_h), .push_src(push_src_h), .drop(drop_h),
    .drop_cnt(drop_cnt_h));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state (spec-level: table, enables, round-robin pointers)
  logic [7:0] m_tab [8];
  logic [7:0] m_en;
  int         m_ptr [8];
  logic [7:0] m_push;
  logic [7:0] m_data [8];
  logic [2:0] m_src [8];
  logic [7:0] m_drop;
  int         m_cnt = 0;
  logic [8:0] m_cfg;
  logic [7:0] exp_rcv, obs_rcv, obs_rcv_h;
  logic [2:0] exp_q[$];

  initial begin
    for (int j = 0; j < 8; j++) m_ptr[j] = 0;
  end

  task automatic idle();
    reset = 1'b0; addr_in = '0; data_in = '0; wr_en = '0;
    port_en = 1'b0; port_wr = 1'b0; port_sel = '0; port_addr = '0;
    fifo_full = '0; fifo_af = '0;
  endtask

  // One clock: sample data_rcv before the edge, predict the cycle from the
  // model, then advance the model to match the registered outputs.
  task automatic step();
    int tgt [8];
    int gs  [8];
    int idx;
    logic [7:0] n_drop;
    @(negedge clk);
    obs_rcv = data_rcv;
    obs_rcv_h = data_rcv_h;
    exp_rcv = '0;
    n_drop = '0;
    for (int i = 0; i < 8; i++) begin
      tgt[i] = -1;
      for (int j = 0; j < 8; j++)
        if (tgt[i] < 0 && m_en[j] === 1'b1 && m_tab[j] === addr_in[8*i +: 8]) tgt[i] = j;
      if (wr_en[i] && tgt[i] < 0) begin
        exp_rcv[i] = 1'b1;
        n_drop[i] = 1'b1;
      end
    end
    for (int j = 0; j < 8; j++) begin
      gs[j] = -1;
      if (!fifo_full[j] && !(m_push[j] === 1'b1 && fifo_af[j])) begin
        for (int k = 0; k < 8; k++) begin
          idx = (m_ptr[j] + k) % 8;
          if (gs[j] < 0 && wr_en[idx] && tgt[idx] == j) gs[j] = idx;
        end
      end
      if (gs[j] >= 0) exp_rcv[gs[j]] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int j = 0; j < 8; j++) begin
        m_tab[j] = 8'(j); m_en[j] = 1'b0; m_ptr[j] = 0; m_data[j] = '0; m_src[j] = '0;
      end
      m_push = '0; m_drop = '0; m_cnt = 0; m_cfg = '0;
    end else begin
      for (int j = 0; j < 8; j++) begin
        m_push[j] = (gs[j] >= 0);
        if (gs[j] >= 0) begin
          m_data[j] = data_in[8*gs[j] +: 8];
          m_src[j] = 3'(gs[j]);
          m_ptr[j] = (gs[j] + 1) % 8;
        end
      end
      m_drop = n_drop;
      m_cnt = m_cnt + $countones(n_drop);
      if (m_cnt > 65535) m_cnt = 65535;
      if (port_en && !port_wr) begin
        m_cfg = '0;
        for (int j = 7; j >= 0; j--) if (port_sel[j]) m_cfg = {m_en[j], m_tab[j]};
      end
      if (port_en && port_wr)
        for (int j = 0; j < 8; j++)
          if (port_sel[j]) begin
            m_tab[j] = port_addr[7:0];
            m_en[j] = port_addr[8];
          end
    end
  endtask

  task automatic cfg_write(input logic [7:0] sel, input logic [7:0] a, input logic en);
    port_en = 1'b1; port_wr = 1'b1; port_sel = sel; port_addr = {7'h0, en, a};
    step();
    port_en = 1'b0; port_wr = 1'b0; port_sel = '0;
  endtask

  task automatic cfg_read(input logic [7:0] sel);
    port_en = 1'b1; port_wr = 1'b0; port_sel = sel;
    step();
    port_en = 1'b0; port_sel = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (push !== 8'h0) begin n_bad++; $display("FAIL reset_push: got %h want 00", push); end
    n_cmp++; if (push_data !== 64'h0) begin n_bad++; $display("FAIL reset_push_data: got %h want 0", push_data); end
    n_cmp++; if (push_src !== 24'h0) begin n_bad++; $display("FAIL reset_push_src: got %h want 0", push_src); end
    n_cmp++; if (drop !== 8'h0) begin n_bad++; $display("FAIL reset_drop: got %h want 00", drop); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt); end
    n_cmp++; if (cfg_rdata !== 9'h0) begin n_bad++; $display("FAIL reset_cfg_rdata: got %h want 0", cfg_rdata); end
    for (int j = 0; j < 8; j++) begin
      cfg_read(8'(1 << j));
      n_cmp++;
      if (cfg_rdata !== {1'b0, 8'(j)}) begin
        n_bad++; $display("FAIL reset_table port %0d: got %h want %h", j, cfg_rdata, {1'b0, 8'(j)});
      end
    end
  endtask

  task automatic test_cfg();
    cfg_write(8'hFF, 8'h55, 1'b1);
    cfg_read(8'h80);
    n_cmp++; if (cfg_rdata !== 9'h155) begin n_bad++; $display("FAIL cfg_broadcast: got %h want 155", cfg_rdata); end
    for (int j = 0; j < 8; j++) cfg_write(8'(1 << j), 8'(8'h10 + j), 1'b1);
    for (int j = 0; j < 8; j++) begin
      cfg_read(8'(1 << j));
      n_cmp++;
      if (cfg_rdata !== {1'b1, 8'(8'h10 + j)}) begin
        n_bad++; $display("FAIL cfg_readback port %0d: got %h want %h", j, cfg_rdata, {1'b1, 8'(8'h10 + j)});
      end
    end
    cfg_read(8'h0C);
    n_cmp++; if (cfg_rdata !== 9'h112) begin n_bad++; $display("FAIL cfg_lowest_sel: got %h want 112", cfg_rdata); end
    cfg_read(8'h00);
    n_cmp++; if (cfg_rdata !== 9'h000) begin n_bad++; $display("FAIL cfg_sel_zero: got %h want 000", cfg_rdata); end
    cfg_read(8'h01);
    step();
    n_cmp++; if (cfg_rdata !== 9'h110) begin n_bad++; $display("FAIL cfg_hold: got %h want 110", cfg_rdata); end
  endtask

  task automatic test_rr();
    logic [7:0] d [8];
    logic [2:0] e;
    idle();
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) data_in[8*i +: 8] = d[i];
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(3'd0); exp_q.push_back(3'd3); exp_q.push_back(3'd5);
    end
    addr_in[0 +: 8] = 8'h12; addr_in[24 +: 8] = 8'h12; addr_in[40 +: 8] = 8'h12;
    wr_en = 8'b0010_1001;
    for (int k = 0; k < 12; k++) begin
      step();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rcv !== 8'(1 << e)) begin
        n_bad++; $display("FAIL rr_rcv step %0d: got %h want %h", k, obs_rcv, 8'(1 << e));
      end
      n_cmp++;
      if (push[2] !== 1'b1 || push_src[8:6] !== e || push_data[23:16] !== d[e]) begin
        n_bad++; $display("FAIL rr_push step %0d: got push %b src %0d data %h want 1 %0d %h",
                          k, push[2], push_src[8:6], push_data[23:16], e, d[e]);
      end
    end
    wr_en = '0;
    step();
    n_cmp++; if (push !== 8'h0) begin n_bad++; $display("FAIL rr_drain: got %h want 00", push); end
  endtask

  task automatic test_all_ports();
    logic [7:0] d [8];
    int o;
    idle();
    for (int i = 0; i < 8; i++) begin
      d[i] = 8'($urandom_range(0, 255));
      data_in[8*i +: 8] = d[i];
      addr_in[8*i +: 8] = 8'(8'h10 + (i + 3) % 8);
    end
    wr_en = 8'hFF;
    step();
    wr_en = '0;
    n_cmp++; if (obs_rcv !== 8'hFF) begin n_bad++; $display("FAIL all_rcv: got %h want ff", obs_rcv); end
    n_cmp++; if (push !== 8'hFF) begin n_bad++; $display("FAIL all_push: got %h want ff", push); end
    for (int i = 0; i < 8; i++) begin
      o = (i + 3) % 8;
      n_cmp++;
      if (push_data[8*o +: 8] !== d[i] || push_src[3*o +: 3] !== 3'(i)) begin
        n_bad++; $display("FAIL all_lane %0d: got data %h src %0d want %h %0d",
                          o, push_data[8*o +: 8], push_src[3*o +: 3], d[i], i);
      end
    end
    step();
    n_cmp++; if (push !== 8'h0) begin n_bad++; $display("FAIL all_single_cycle: got %h want 00", push); end
  endtask

  task automatic test_backpressure();
    idle();
    addr_in[8 +: 8] = 8'h14;
    data_in[8 +: 8] = 8'($urandom_range(0, 255));
    wr_en = 8'h02;
    fifo_af[4] = 1'b1;
    // almost full: a grant is followed by a skipped cycle
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (obs_rcv[1] !== ((k % 2) == 0) || push[4] !== ((k % 2) == 0)) begin
        n_bad++; $display("FAIL af_gap step %0d: got rcv %b push %b want %b", k, obs_rcv[1], push[4], (k % 2) == 0);
      end
    end
    fifo_af[4] = 1'b0;
    fifo_full[4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (obs_rcv[1] !== 1'b0 || push[4] !== 1'b0) begin
        n_bad++; $display("FAIL full_block step %0d: got rcv %b push %b want 0 0", k, obs_rcv[1], push[4]);
      end
    end
    fifo_full[4] = 1'b0;
    step();
    n_cmp++;
    if (obs_rcv[1] !== 1'b1 || push[4] !== 1'b1 || push_src[14:12] !== 3'd1) begin
      n_bad++; $display("FAIL full_release: got rcv %b push %b src %0d want 1 1 1", obs_rcv[1], push[4], push_src[14:12]);
    end
    wr_en = '0;
    step();
  endtask

  task automatic test_drop();
    idle();
    addr_in[48 +: 8] = 8'h99;
    data_in[48 +: 8] = 8'hA5;
    wr_en = 8'h40;
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL drop_start: got %0d want 0", drop_cnt); end
    step();
    n_cmp++; if (obs_rcv !== 8'h40) begin n_bad++; $display("FAIL drop_rcv: got %h want 40", obs_rcv); end
    n_cmp++; if (obs_rcv_h !== 8'h00) begin n_bad++; $display("FAIL hold_rcv: got %h want 00", obs_rcv_h); end
    n_cmp++; if (drop !== 8'h40 || push !== 8'h00) begin n_bad++; $display("FAIL drop_pulse: got drop %h push %h want 40 00", drop, push); end
    n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL drop_cnt1: got %0d want 1", drop_cnt); end
    n_cmp++; if (drop_h !== 8'h00 || drop_cnt_h !== 16'd0) begin n_bad++; $display("FAIL hold_nodrop: got %h %0d want 00 0", drop_h, drop_cnt_h); end
    step();
    n_cmp++; if (drop_cnt !== 16'd2 || obs_rcv_h[6] !== 1'b0) begin n_bad++; $display("FAIL drop_cnt2: got %0d rcv_h %b want 2 0", drop_cnt, obs_rcv_h[6]); end
    wr_en = '0;
    step();
    n_cmp++; if (drop !== 8'h00 || drop_cnt !== 16'd2) begin n_bad++; $display("FAIL drop_end: got %h %0d want 00 2", drop, drop_cnt); end
  endtask

  task automatic test_random();
    int r;
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        addr_in[8*i +: 8] = (r < 8) ? 8'(8'h10 + r) : (r == 8) ? 8'h99 : 8'($urandom_range(0, 255));
        data_in[8*i +: 8] = 8'($urandom_range(0, 255));
      end
      wr_en = 8'($urandom);
      fifo_full = 8'($urandom & $urandom & $urandom);
      fifo_af = 8'($urandom & $urandom);
      r = $urandom_range(0, 15);
      port_en = (r < 2);
      port_wr = (r == 0);
      port_sel = 8'($urandom_range(0, 255));
      port_addr = {7'h0, 1'($urandom_range(0, 3) != 0), 8'(8'h10 + $urandom_range(0, 7))};
      step();
      n_cmp++; if (obs_rcv !== exp_rcv) begin n_bad++; $display("FAIL rnd_rcv cyc %0d: got %h want %h", c, obs_rcv, exp_rcv); end
      n_cmp++; if (push !== m_push) begin n_bad++; $display("FAIL rnd_push cyc %0d: got %h want %h", c, push, m_push); end
      for (int j = 0; j < 8; j++) begin
        if (m_push[j]) begin
          n_cmp++;
          if (push_data[8*j +: 8] !== m_data[j] || push_src[3*j +: 3] !== m_src[j]) begin
            n_bad++; $display("FAIL rnd_lane cyc %0d out %0d: got %h/%0d want %h/%0d",
                              c, j, push_data[8*j +: 8], push_src[3*j +: 3], m_data[j], m_src[j]);
          end
        end
      end
      n_cmp++; if (drop !== m_drop) begin n_bad++; $display("FAIL rnd_drop cyc %0d: got %h want %h", c, drop, m_drop); end
      n_cmp++; if (drop_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_drop_cnt cyc %0d: got %0d want %0d", c, drop_cnt, m_cnt); end
      n_cmp++; if (cfg_rdata !== m_cfg) begin n_bad++; $display("FAIL rnd_cfg cyc %0d: got %h want %h", c, cfg_rdata, m_cfg); end
      n_cmp++; if (drop_cnt_h !== 16'd0) begin n_bad++; $display("FAIL rnd_hold_cnt cyc %0d: got %0d want 0", c, drop_cnt_h); end
    end
    idle();
    step();
  endtask

  task automatic test_saturate();
    idle();
    for (int i = 0; i < 8; i++) addr_in[8*i +: 8] = 8'h99;
    wr_en = 8'hFF;
    for (int k = 0; k < 9000 && m_cnt < 65535; k++) step();
    n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach: got %h want ffff", drop_cnt); end
    step();
    n_cmp++; if (drop_cnt !== 16'hFFFF || drop !== 8'hFF) begin n_bad++; $display("FAIL sat_hold: got %h drop %h want ffff ff", drop_cnt, drop); end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    idle();
    cfg_write(8'h01, 8'h10, 1'b1);
    addr_in[0 +: 8] = 8'h10;
    addr_in[8 +: 8] = 8'h99;
    wr_en = 8'h03;
    step();
    n_cmp++; if (push[0] !== 1'b1) begin n_bad++; $display("FAIL mid_inflight: got %b want 1", push[0]); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr_en = '0;
    n_cmp++; if (push !== 8'h0 || drop !== 8'h0) begin n_bad++; $display("FAIL mid_push: got %h drop %h want 00 00", push, drop); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); end
    for (int j = 0; j < 8; j++) begin
      cfg_read(8'(1 << j));
      n_cmp++;
      if (cfg_rdata !== {1'b0, 8'(j)}) begin
        n_bad++; $display("FAIL mid_table port %0d: got %h want %h", j, cfg_rdata, {1'b0, 8'(j)});
      end
    end
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_cfg();
    test_rr();
    test_all_ports();
    test_backpressure();
    test_drop();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
